// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash model: FSM states, opcodes, counter widths.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    ID,
    STATUS,
    IGNORE
  } state_t;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_RDSR      = 8'h05;

  localparam int BIT_CNT_W  = 3;
  localparam int ADDR_CNT_W = 2;
  localparam int ID_CNT_W   = 2;

endpackage

// File: rtl/spi_flash_sync_edge.sv
// Two-flop synchronizer for one asynchronous bit, with rise/fall detection on the synced value.
module spi_flash_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  // stages [1:0] synchronize; stage [2] is the previous synced value for edge detect
  logic [2:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) ff <= {3{RESET_VAL}};
    else        ff <= {ff[1:0], d};
  end

  assign sync = ff[1];
  assign rise = ff[1] & ~ff[2];
  assign fall = ~ff[1] & ff[2];

endmodule

// File: rtl/spi_flash_model.sv
// SPI mode-0 flash model decoding READ, READ ID and READ STATUS over a combinational word memory.
// Optional fast read (opcode 0x0B plus one dummy byte) is enabled by defining SPI_FLASH_FAST_READ_EN.
module spi_flash_model
  import spi_flash_pkg::*;
#(
  parameter int          ADDR_BYTES      = 3,
  parameter int          MEM_DEPTH_WORDS = 1024,
  parameter logic [23:0] JEDEC_ID        = 24'hEF4016
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ss,
  input  logic                               sck,
  input  logic                               mosi,
  output logic                               miso,
  output logic [$clog2(MEM_DEPTH_WORDS)-1:0] mem_addr,
  input  logic [31:0]                        mem_rdata,
  output logic                               busy,
  output logic                               cmd_err
);

  localparam int WA_W = $clog2(MEM_DEPTH_WORDS);
  localparam int BA_W = WA_W + 2;

  logic ss_sync, ss_rise, ss_fall;
  logic sck_sync, sck_rise, sck_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  // ss idles high so busy reads 0 straight out of reset
  spi_flash_sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .d(ss), .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );
  spi_flash_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(sck), .sync(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );
  spi_flash_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sck_sync, mosi_rise, mosi_fall};

  state_t                state, state_next;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [ADDR_CNT_W-1:0] addr_cnt;
  logic [ID_CNT_W-1:0]   id_cnt;
  logic [7:0]            rx_shift, tx_shift, resp;
  logic [BA_W-1:0]       byte_addr;
  logic [BA_W+7:0]       addr_shift;
  logic                  byte_done, load_pending, cmd_err_next, addr_last;
`ifdef SPI_FLASH_FAST_READ_EN
  logic                  fast_q;
`endif

  assign addr_shift = {byte_addr, rx_shift};
  assign addr_last  = (addr_cnt == ADDR_CNT_W'(ADDR_BYTES - 1));
  assign mem_addr   = byte_addr[2 +: WA_W];
  assign miso       = tx_shift[7] & ~ss_sync;
  assign busy       = ~ss_sync;

  // A synced ss rise overrides any byte completing in the same cycle.
  always_comb begin
    state_next   = state;
    cmd_err_next = 1'b0;
    if (ss_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (ss_fall) state_next = CMD;
        CMD: if (byte_done) begin
          case (rx_shift)
            OP_READ: state_next = ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
            OP_FAST_READ: state_next = ADDR;
`endif
            OP_RDID: state_next = ID;
            OP_RDSR: state_next = STATUS;
            default: begin
              state_next   = IGNORE;
              cmd_err_next = 1'b1;
            end
          endcase
        end
`ifdef SPI_FLASH_FAST_READ_EN
        ADDR:  if (byte_done && addr_last) state_next = fast_q ? DUMMY : DATA;
        DUMMY: if (byte_done) state_next = DATA;
`else
        ADDR:  if (byte_done && addr_last) state_next = DATA;
`endif
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    resp = 8'h00;
    case (state)
      DATA: resp = mem_rdata[{byte_addr[1:0], 3'b000} +: 8];
      ID: begin
        case (id_cnt)
          2'd0:    resp = JEDEC_ID[23:16];
          2'd1:    resp = JEDEC_ID[15:8];
          2'd2:    resp = JEDEC_ID[7:0];
          default: resp = 8'h00;
        endcase
      end
      default: resp = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd_err      <= 1'b0;
      bit_cnt      <= '0;
      addr_cnt     <= '0;
      id_cnt       <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      byte_addr    <= '0;
      byte_done    <= 1'b0;
      load_pending <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q       <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cmd_err   <= cmd_err_next;
      byte_done <= 1'b0;
      if (ss_sync) begin
        // deselected: drop any partial byte and pending response
        bit_cnt      <= '0;
        addr_cnt     <= '0;
        id_cnt       <= '0;
        rx_shift     <= '0;
        tx_shift     <= '0;
        load_pending <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_shift  <= {rx_shift[6:0], mosi_sync};
          bit_cnt   <= bit_cnt + 1'b1;
          byte_done <= (bit_cnt == BIT_CNT_W'(7));
        end
        if (byte_done) begin
          load_pending <= 1'b1;
          if (state == ADDR) begin
            byte_addr <= addr_shift[BA_W-1:0];
            addr_cnt  <= addr_cnt + 1'b1;
          end
`ifdef SPI_FLASH_FAST_READ_EN
          if (state == CMD) fast_q <= (rx_shift == OP_FAST_READ);
`endif
        end
        if (sck_fall) begin
          if (load_pending) begin
            tx_shift     <= resp;
            load_pending <= 1'b0;
            if (state == DATA) byte_addr <= byte_addr + 1'b1;
            if (state == ID && id_cnt != 2'd3) id_cnt <= id_cnt + 1'b1;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
